// File: rtl/vram_pkg.sv
// Shared types and helpers for the ZBT frame-buffer display reader.
// Pixels are 18-bit YCrCb {Y[17:10], Cr[9:5], Cb[4:0]}; two pixels per 36-bit word.
package vram_pkg;

  localparam int PIX_W  = 18;
  localparam int WORD_W = 36;
  localparam int ADDR_W = 19;

  localparam int LINE_W = 9;
  localparam int WIDX_W = 9;

  localparam int Y_MSB  = 17;
  localparam int Y_LSB  = 10;
  localparam int CR_MSB = 9;
  localparam int CR_LSB = 5;
  localparam int CB_MSB = 4;
  localparam int CB_LSB = 0;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  function automatic addr_t pack_addr(input logic [LINE_W-1:0] line,
                                      input logic              field,
                                      input logic [WIDX_W-1:0] word_idx);
    return {line, field, word_idx};
  endfunction

  // Even columns live in the upper half of the word, odd columns in the lower half.
  function automatic pixel_t unpack_pixel(input word_t word, input logic odd);
    pixel_t half;
    half = odd ? word[PIX_W-1:0] : word[WORD_W-1:PIX_W];
    return {half[Y_MSB:Y_LSB], half[CR_MSB:CR_LSB], half[CB_MSB:CB_LSB]};
  endfunction

endpackage

// File: rtl/vram_reader_if.sv
// ZBT read port as seen by the display reader: address/strobe out, read data back.
interface vram_reader_if;
  import vram_pkg::*;

  addr_t vram_addr;
  logic  vram_rd;
  word_t vram_read_data;

  modport master (output vram_addr, output vram_rd, input vram_read_data);
  modport slave  (input vram_addr, input vram_rd, output vram_read_data);

endinterface

// File: rtl/vram_addr_gen.sv
// Fetch-ahead address generator: looks FORECAST columns ahead of the raster and
// issues one ZBT read per pixel pair. VRAM_LINE_DOUBLE_EN forces field 0 (bob deinterlace).
module vram_addr_gen
  import vram_pkg::*;
#(
  parameter int H_TOTAL    = 1344,
  parameter int V_TOTAL    = 806,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output addr_t       vram_addr,
  output logic        vram_rd
);

  localparam int FORECAST = RD_LATENCY + 3;

  logic [11:0] f_raw;
  logic [11:0] fetch_col;
  logic [9:0]  fetch_row;
  logic        field;
  logic        issue;

  // Lookahead past the end of the line lands on the start of the next row,
  // which is how column 0 gets prefetched during horizontal blanking.
  always_comb begin
    f_raw     = {1'b0, hcount} + 12'(FORECAST);
    fetch_col = f_raw;
    fetch_row = vcount;
    if (f_raw >= 12'(H_TOTAL)) begin
      fetch_col = f_raw - 12'(H_TOTAL);
      fetch_row = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    end
    issue = !fetch_col[0] && (fetch_col < 12'(IMG_W)) && (fetch_row < 10'(IMG_H));
  end

`ifdef VRAM_LINE_DOUBLE_EN
  assign field = 1'b0;
`else
  assign field = fetch_row[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr <= '0;
      vram_rd   <= 1'b0;
    end else begin
      vram_rd <= issue;
      if (issue) begin
        vram_addr <= pack_addr(fetch_row[9:1], field, fetch_col[9:1]);
      end
    end
  end

endmodule

// File: rtl/vram_reader.sv
// Display-side ZBT frame-buffer reader: prefetches words ahead of the XGA raster
// and emits one registered YCrCb pixel per clock. Honours VRAM_LINE_DOUBLE_EN via vram_addr_gen.
module vram_reader
  import vram_pkg::*;
#(
  parameter int H_TOTAL    = 1344,
  parameter int V_TOTAL    = 806,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int RD_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [10:0]  hcount,
  input  logic [9:0]   vcount,
  vram_reader_if.master bus,
  output pixel_t       pixel,
  output logic         pixel_valid
);

  logic [RD_LATENCY:0] tag_pipe;
  word_t               word_reg;
  logic                in_image;

  vram_addr_gen #(
    .H_TOTAL   (H_TOTAL),
    .V_TOTAL   (V_TOTAL),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .RD_LATENCY(RD_LATENCY)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .hcount   (hcount),
    .vcount   (vcount),
    .vram_addr(bus.vram_addr),
    .vram_rd  (bus.vram_rd)
  );

  // The tag pipe marks which returning data belongs to our reads, so clearing
  // it on reset drops anything that was already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_pipe <= '0;
      word_reg <= '0;
    end else begin
      tag_pipe <= {tag_pipe[RD_LATENCY-1:0], bus.vram_rd};
      if (tag_pipe[RD_LATENCY]) begin
        word_reg <= bus.vram_read_data;
      end
    end
  end

  assign in_image = (hcount < 11'(IMG_W)) && (vcount < 10'(IMG_H));

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel       <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= in_image;
      pixel       <= in_image ? unpack_pixel(word_reg, hcount[0]) : '0;
    end
  end

endmodule

// File: tb/tb_vram_reader.sv
// Scoreboard bench for vram_reader: drives raster segments against a ZBT model
// returning {addr[17:0], ~addr[17:0]} and compares every output cycle.
module tb_vram_reader;
  import vram_pkg::*;

  localparam int H_TOTAL    = 1344;
  localparam int V_TOTAL    = 806;
  localparam int IMG_W      = 640;
  localparam int IMG_H      = 480;
  localparam int RD_LATENCY = 2;
  localparam int FORECAST   = RD_LATENCY + 3;

  typedef struct {
    bit     chkPix;
    pixel_t pix;
    logic   pv;
    logic   rd;
    addr_t  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  pixel_t      pixel;
  logic        pixel_valid;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   rdCount = 0;
  int   zeroCnt = 0;
  int   skipCnt = 0;

  vram_reader_if vbus();

  vram_reader #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .IMG_W(IMG_W),
    .IMG_H(IMG_H), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .bus        (vbus),
    .pixel      (pixel),
    .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  function automatic word_t memWord(input addr_t a);
    return {a[17:0], ~a[17:0]};
  endfunction

  // ZBT model: data reflects the address presented RD_LATENCY clocks earlier.
  addr_t a1, a2;
  always @(posedge clk) begin
    a1 <= vbus.vram_addr;
    a2 <= a1;
  end
  assign vbus.vram_read_data = memWord(a2);

  function automatic addr_t pixAddr(input int col, input int row);
    addr_t      a;
    logic [9:0] r;
    logic [9:0] c;
    r = 10'(row);
    c = 10'(col);
    a[18:10] = r[9:1];
`ifdef VRAM_LINE_DOUBLE_EN
    a[9] = 1'b0;
`else
    a[9] = r[0];
`endif
    a[8:0] = c[9:1];
    return a;
  endfunction

  function automatic bit fetchIssue(input int h, input int v);
    int f = h + FORECAST;
    int r = v;
    if (f >= H_TOTAL) begin
      f = f - H_TOTAL;
      r = (v == V_TOTAL - 1) ? 0 : v + 1;
    end
    return (f % 2 == 0) && (f < IMG_W) && (r < IMG_H);
  endfunction

  function automatic addr_t fetchAddr(input int h, input int v);
    int f = h + FORECAST;
    int r = v;
    if (f >= H_TOTAL) begin
      f = f - H_TOTAL;
      r = (v == V_TOTAL - 1) ? 0 : v + 1;
    end
    return pixAddr(f, r);
  endfunction

  function automatic pixel_t expPixel(input int h, input int v);
    word_t w = memWord(pixAddr(h, v));
    return (h % 2 == 1) ? w[17:0] : w[35:18];
  endfunction

  task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (h=%0d v=%0d)", tag, observed, expected, hcount, vcount);
    end
  endtask

  task automatic applyStimulus(input logic rst, input int h, input int v);
    exp_t e;
    reset  = rst;
    hcount = 11'(h);
    vcount = 10'(v);
    e.chkPix = 1'b1;
    e.pix    = '0;
    e.pv     = 1'b0;
    e.rd     = 1'b0;
    e.addr   = '0;
    if (!rst) begin
      e.pv   = (h < IMG_W) && (v < IMG_H);
      e.rd   = fetchIssue(h, v);
      e.addr = fetchAddr(h, v);
      if (e.pv) begin
        if (zeroCnt > 0) e.pix = '0;
        else if (skipCnt > 0) e.chkPix = 1'b0;
        else e.pix = expPixel(h, v);
      end
      if (zeroCnt > 0) zeroCnt--;
      else if (skipCnt > 0) skipCnt--;
    end else begin
      zeroCnt = FORECAST;
      skipCnt = 1;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput("pixel_valid", 36'(pixel_valid), 36'(e.pv));
    if (e.chkPix) checkOutput("pixel", 36'(pixel), 36'(e.pix));
    checkOutput("vram_rd", 36'(vbus.vram_rd), 36'(e.rd));
    if (e.rd) checkOutput("vram_addr", 36'(vbus.vram_addr), 36'(e.addr));
    if (rst) checkOutput("rst_addr", 36'(vbus.vram_addr), 36'd0);
    if (vbus.vram_rd) rdCount++;
  endtask

  task automatic runRange(input int v0, input int h0, input int n, input bit fresh);
    int h = h0;
    int v = v0;
    if (fresh) begin
      zeroCnt = 0;
      skipCnt = FORECAST + 1;
    end
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, h, v);
      h++;
      if (h == H_TOTAL) begin
        h = 0;
        v = (v + 1) % V_TOTAL;
      end
    end
  endtask

  initial begin
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b1, 0, 0);

    rdCount = 0;
    runRange(3, 1330, 714, 1'b1);
    checkOutput("reads_line4", 36'(rdCount), 36'd320);

    rdCount = 0;
    runRange(4, 1330, 714, 1'b1);
    checkOutput("reads_line5", 36'(rdCount), 36'd320);

    rdCount = 0;
    runRange(480, 600, 800, 1'b1);
    checkOutput("reads_blank", 36'(rdCount), 36'd0);

    rdCount = 0;
    runRange(805, 1300, 744, 1'b1);
    checkOutput("reads_wrap", 36'(rdCount), 36'd320);

    runRange(20, 1330, 214, 1'b1);
    applyStimulus(1'b1, 200, 20);
    runRange(20, 201, 100, 1'b0);

    runRange(10, 1330, 115, 1'b1);
    runRange(10, 400, 60, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
